// File: rtl/sram_burst_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_burst_controller_pkg
//  Description : Shared constants for the SRAM burst controller: controller
//                state encoding, default SRAM geometry and pin tie-offs.
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_burst_controller_pkg;

    // Default SRAM geometry (16-bit data, 256K words)
    localparam int c_SRAM_DATA_WIDTH = 16;
    localparam int c_SRAM_ADDR_WIDTH = 18;

    // Wait counter width; covers WAIT_CYCLES 0..15
    localparam int c_WAIT_WIDTH = 4;
    localparam int c_MAX_WAIT   = 15;

    // SRAM pin levels
    localparam logic c_TIE_LOW      = 1'b0;
    localparam logic c_WE_INACTIVE  = 1'b1;

    // Controller state encoding
    localparam int c_STATE_WIDTH = 2;
    typedef logic [c_STATE_WIDTH-1:0] state_t;
    localparam state_t c_ST_IDLE   = 2'd0;
    localparam state_t c_ST_ACCESS = 2'd1;
    localparam state_t c_ST_DONE   = 2'd2;

    // Beat index width; a single-beat configuration still needs one bit
    function automatic int beat_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_burst_controller_beat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_beat_counter
//  Description : Beat and wait-state counters for one SRAM burst. Flags the
//                last cycle of the current beat and the final beat.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_beat_counter
    import sram_burst_controller_pkg::*;
#(
    parameter int BEATS       = 2,
    parameter int WAIT_CYCLES = 1,
    parameter int BEAT_WIDTH  = beat_width(BEATS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clear,
    input  logic                  i_enable,
    output logic [BEAT_WIDTH-1:0] o_beat,
    output logic                  o_last_cycle,
    output logic                  o_last_beat
);

    localparam logic [c_WAIT_WIDTH-1:0] c_LAST_WAIT = c_WAIT_WIDTH'(WAIT_CYCLES);
    localparam logic [BEAT_WIDTH-1:0]   c_LAST_BEAT = BEAT_WIDTH'(BEATS - 1);

    logic [BEAT_WIDTH-1:0]   r_beat;
    logic [c_WAIT_WIDTH-1:0] r_wait;

    // Count wait cycles within a beat, then step to the next beat (wrapping after the last)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat <= '0;
            r_wait <= '0;
        end else if (i_clear) begin
            r_beat <= '0;
            r_wait <= '0;
        end else if (i_enable) begin
            if (o_last_cycle) begin
                r_wait <= '0;
                r_beat <= o_last_beat ? '0 : r_beat + 1'b1;
            end else begin
                r_wait <= r_wait + 1'b1;
            end
        end
    end

    assign o_beat       = r_beat;
    assign o_last_cycle = (r_wait == c_LAST_WAIT);
    assign o_last_beat  = (r_beat == c_LAST_BEAT);

endmodule
`default_nettype wire

// File: rtl/sram_burst_controller.sv
`default_nettype none
// ============================================================================
//  Module      : sram_burst_controller
//  Description : Splits CPU word reads/writes into a burst of narrower SRAM
//                beats, each held for WAIT_CYCLES+1 clocks; ready is held low
//                while a transfer is in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_burst_controller
    import sram_burst_controller_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int SRAM_DATA_WIDTH = c_SRAM_DATA_WIDTH,
    parameter int SRAM_ADDR_WIDTH = c_SRAM_ADDR_WIDTH,
    parameter int WAIT_CYCLES     = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic                       rd_en,
    input  logic [ADDR_WIDTH-1:0]      address,
    input  logic [DATA_WIDTH-1:0]      write_data,
    output logic [DATA_WIDTH-1:0]      read_data,
    output logic                       ready,
    inout  wire  [SRAM_DATA_WIDTH-1:0] SRAM_DQ,
    output logic [SRAM_ADDR_WIDTH-1:0] SRAM_ADDR,
    output logic                       SRAM_WE_N,
    output logic                       SRAM_UB_N,
    output logic                       SRAM_LB_N,
    output logic                       SRAM_CE_N,
    output logic                       SRAM_OE_N
);

    localparam int c_BEATS      = DATA_WIDTH / SRAM_DATA_WIDTH;
    localparam int c_BEAT_WIDTH = beat_width(c_BEATS);
    localparam int c_BYTE_SHIFT = $clog2(DATA_WIDTH / 8);

    // Reject geometries that do not split into a whole number of beats
    if (((DATA_WIDTH % SRAM_DATA_WIDTH) != 0) || (c_BEATS < 1)) begin : g_bad_width
        $error("DATA_WIDTH must be a positive multiple of SRAM_DATA_WIDTH");
    end
    if ((WAIT_CYCLES < 0) || (WAIT_CYCLES > c_MAX_WAIT)) begin : g_bad_wait
        $error("WAIT_CYCLES must be in 0..15");
    end

    state_t                     r_state;
    state_t                     w_next_state;
    logic [SRAM_ADDR_WIDTH-1:0] r_word;
    logic [DATA_WIDTH-1:0]      r_wdata;
    logic [DATA_WIDTH-1:0]      r_rbuf;
    logic [DATA_WIDTH-1:0]      r_read_data;
    logic                       r_is_write;
    logic [DATA_WIDTH-1:0]      w_rword;
    logic [ADDR_WIDTH-1:0]      w_word_index;
    logic                       w_start;
    logic                       w_access;
    logic                       w_dq_drive;
    logic [c_BEAT_WIDTH-1:0]    w_beat;
    logic                       w_last_cycle;
    logic                       w_last_beat;

    sram_beat_counter #(
        .BEATS       (c_BEATS),
        .WAIT_CYCLES (WAIT_CYCLES),
        .BEAT_WIDTH  (c_BEAT_WIDTH)
    ) u_beat_counter (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_start),
        .i_enable     (w_access),
        .o_beat       (w_beat),
        .o_last_cycle (w_last_cycle),
        .o_last_beat  (w_last_beat)
    );

    assign w_word_index = address >> c_BYTE_SHIFT;
    assign w_access     = (r_state == c_ST_ACCESS);
    assign w_dq_drive   = w_access && r_is_write;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state and ready; a simultaneous read+write request is taken as a write
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        ready        = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                ready = !(wr_en || rd_en);
                if (wr_en || rd_en) begin
                    w_start      = 1'b1;
                    w_next_state = c_ST_ACCESS;
                end
            end
            c_ST_ACCESS: begin
                if (w_last_cycle && w_last_beat) w_next_state = c_ST_DONE;
            end
            c_ST_DONE: begin
                ready        = 1'b1;
                w_next_state = c_ST_IDLE;
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // Latch the request so the burst ignores the live inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word     <= '0;
            r_wdata    <= '0;
            r_is_write <= 1'b0;
        end else if (w_start) begin
            r_word     <= w_word_index[SRAM_ADDR_WIDTH-1:0];
            r_wdata    <= write_data;
            r_is_write <= wr_en;
        end
    end

    // Merge the beat arriving on the bus into the partial read word
    always_comb begin
        w_rword = r_rbuf;
        w_rword[w_beat*SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH] = SRAM_DQ;
    end

    // Capture each read beat on its last cycle; publish only once the whole word is in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rbuf      <= '0;
            r_read_data <= '0;
        end else if (w_access && !r_is_write && w_last_cycle) begin
            r_rbuf <= w_rword;
            if (w_last_beat) r_read_data <= w_rword;
        end
    end

    assign read_data = r_read_data;
    assign SRAM_ADDR = r_word * SRAM_ADDR_WIDTH'(c_BEATS) + SRAM_ADDR_WIDTH'(w_beat);
    assign SRAM_WE_N = w_dq_drive ? 1'b0 : c_WE_INACTIVE;
    assign SRAM_DQ   = w_dq_drive ? r_wdata[w_beat*SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH]
                                  : {SRAM_DATA_WIDTH{1'bz}};
    assign SRAM_UB_N = c_TIE_LOW;
    assign SRAM_LB_N = c_TIE_LOW;
    assign SRAM_CE_N = c_TIE_LOW;
    assign SRAM_OE_N = c_TIE_LOW;

endmodule
`default_nettype wire

// File: tb/tb_sram_burst_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_burst_controller
//  Description : Self-checking bench. Main instance (32/16, one wait state)
//                is checked every cycle against a transaction-level model;
//                two extra instances cover zero wait states and a one-beat
//                geometry with directed checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_burst_controller;

    localparam int c_WAIT1   = 1;
    localparam int c_ACCESS1 = 2 * (c_WAIT1 + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- main instance: 32-bit word, 16-bit SRAM, 1 wait ----------------
    logic        wr1 = 1'b0, rd1 = 1'b0;
    logic [31:0] addr1 = '0, wdata1 = '0, rdata1;
    logic        ready1, we1, ub1, lb1, ce1, oe1;
    logic [17:0] sa1;
    wire  [15:0] dq1;

    sram_burst_controller #(.WAIT_CYCLES(c_WAIT1)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr1), .rd_en(rd1), .address(addr1),
        .write_data(wdata1), .read_data(rdata1), .ready(ready1), .SRAM_DQ(dq1),
        .SRAM_ADDR(sa1), .SRAM_WE_N(we1), .SRAM_UB_N(ub1), .SRAM_LB_N(lb1),
        .SRAM_CE_N(ce1), .SRAM_OE_N(oe1)
    );

    function automatic logic [15:0] init1(input int i);
        return 16'(i) ^ 16'h5A5A;
    endfunction

    // Behavioural SRAM attached to the main instance
    logic [15:0] mem1 [0:1023];
    assign dq1 = we1 ? mem1[sa1[9:0]] : 16'bz;
    always @(posedge clk) if (!we1) mem1[sa1[9:0]] = dq1;

    // Transaction model: phase 0 idle, 1 access (k = access cycle), 2 done
    int          m_phase = 0;
    int          m_k = 0;
    logic [31:0] m_word = '0, m_data = '0, m_rd = '0;
    logic        m_wr = 1'b0;
    logic [15:0] m_mem [0:1023];

    initial for (int i = 0; i < 1024; i++) begin
        mem1[i]  = init1(i);
        m_mem[i] = init1(i);
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_k = 0; m_rd = '0;
        end else begin
            case (m_phase)
                0: if (wr1 || rd1) begin
                    m_phase = 1; m_k = 0; m_word = addr1 >> 2; m_data = wdata1; m_wr = wr1;
                end
                1: if (m_k == c_ACCESS1 - 1) begin
                    m_phase = 2;
                    if (m_wr) begin
                        m_mem[(m_word * 2) % 1024]     = m_data[15:0];
                        m_mem[(m_word * 2 + 1) % 1024] = m_data[31:16];
                    end else begin
                        m_rd = {m_mem[(m_word * 2 + 1) % 1024], m_mem[(m_word * 2) % 1024]};
                    end
                end else m_k++;
                default: m_phase = 0;
            endcase
        end
    end

    // Compare the main instance against the model every cycle
    always @(negedge clk) begin : cmp
        logic exp_ready;
        int   b;
        exp_ready = (m_phase == 0) ? !(wr1 || rd1) : (m_phase == 2);
        chk("ready", ready1, exp_ready);
        chk("read_data", rdata1, m_rd);
        if (m_phase == 1) begin
            b = m_k / (c_WAIT1 + 1);
            chk("sram_addr", sa1, 18'(m_word * 2 + b));
            chk("we_n_access", we1, !m_wr);
            if (m_wr) chk("dq_write", dq1, m_data[b*16 +: 16]);
            else      chk("dq_released_read", dut1.w_dq_drive, 1'b0);
        end else begin
            chk("we_n_idle", we1, 1'b1);
            chk("dq_released_idle", dut1.w_dq_drive, 1'b0);
        end
    end

    // Issue one request on the main instance; returns cycles until ready (-1 on timeout)
    task automatic run1(input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] d, output int lat);
        lat = -1;
        wr1 = w; rd1 = r; addr1 = a; wdata1 = d;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (ready1) begin lat = n; break; end
        end
        @(posedge clk); #1;
        wr1 = 1'b0; rd1 = 1'b0;
    endtask

    // ---------------- instance 2: zero wait states ----------------
    logic        rd2 = 1'b0;
    logic [31:0] addr2 = '0, rdata2;
    logic        ready2, we2, ub2, lb2, ce2, oe2;
    logic [17:0] sa2;
    wire  [15:0] dq2;
    logic [15:0] mem2 [0:15];
    initial for (int i = 0; i < 16; i++) mem2[i] = 16'hA000 + 16'(i);
    assign dq2 = we2 ? mem2[sa2[3:0]] : 16'bz;

    sram_burst_controller #(.WAIT_CYCLES(0)) dut2 (
        .clk(clk), .rst(rst), .wr_en(1'b0), .rd_en(rd2), .address(addr2),
        .write_data(32'h0), .read_data(rdata2), .ready(ready2), .SRAM_DQ(dq2),
        .SRAM_ADDR(sa2), .SRAM_WE_N(we2), .SRAM_UB_N(ub2), .SRAM_LB_N(lb2),
        .SRAM_CE_N(ce2), .SRAM_OE_N(oe2)
    );

    // ---------------- instance 3: single-beat 16-bit word ----------------
    logic        wr3 = 1'b0, rd3 = 1'b0;
    logic [31:0] addr3 = '0;
    logic [15:0] wdata3 = '0, rdata3;
    logic        ready3, we3, ub3, lb3, ce3, oe3;
    logic [17:0] sa3;
    wire  [15:0] dq3;
    logic [15:0] mem3 [0:15];
    initial for (int i = 0; i < 16; i++) mem3[i] = 16'h0;
    assign dq3 = we3 ? mem3[sa3[3:0]] : 16'bz;
    always @(posedge clk) if (!we3) mem3[sa3[3:0]] = dq3;

    sram_burst_controller #(.DATA_WIDTH(16)) dut3 (
        .clk(clk), .rst(rst), .wr_en(wr3), .rd_en(rd3), .address(addr3),
        .write_data(wdata3), .read_data(rdata3), .ready(ready3), .SRAM_DQ(dq3),
        .SRAM_ADDR(sa3), .SRAM_WE_N(we3), .SRAM_UB_N(ub3), .SRAM_LB_N(lb3),
        .SRAM_CE_N(ce3), .SRAM_OE_N(oe3)
    );

    // ---------------- directed sequence ----------------
    initial begin
        int          lat;
        logic [7:0]  pat;
        logic [31:0] rda, rdb;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", ready1, 1'b1);
        chk("rst_read_data", rdata1, 32'h0);
        chk("rst_we_n", we1, 1'b1);
        chk("rst_sram_addr", sa1, 18'h0);
        chk("rst_dq_released", dut1.w_dq_drive, 1'b0);
        chk("tie_offs", {ub1, lb1, ce1, oe1, ub2, lb2, ce2, oe2, ub3, lb3, ce3, oe3}, 12'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        run1(1'b1, 1'b0, 32'h408, 32'hDEADBEEF, lat);
        chk("wr_latency", lat, 5);
        chk("wr_mem_204", mem1[10'h204], 16'hBEEF);
        chk("wr_mem_205", mem1[10'h205], 16'hDEAD);

        run1(1'b0, 1'b1, 32'h408, 32'h0, lat);
        chk("rd_latency", lat, 5);
        chk("rd_word", rdata1, 32'hDEADBEEF);

        run1(1'b1, 1'b1, 32'h10, 32'h12345678, lat);
        chk("both_latency", lat, 5);
        chk("both_mem_8", mem1[10'h8], 16'h5678);
        chk("both_mem_9", mem1[10'h9], 16'h1234);
        chk("both_read_data_kept", rdata1, 32'hDEADBEEF);

        run1(1'b0, 1'b1, 32'h10, 32'h0, lat);
        chk("rd_back_10", rdata1, 32'h12345678);

        run1(1'b0, 1'b1, 32'h40, 32'h0, lat);
        chk("rd_untouched_40", rdata1, 32'h5A7B5A7A);

        // Reset in the second cycle of the first write beat
        wr1 = 1'b1; addr1 = 32'h100; wdata1 = 32'hCAFEF00D;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1; wr1 = 1'b0;
        #1;
        chk("abort_we_n", we1, 1'b1);
        chk("abort_dq_released", dut1.w_dq_drive, 1'b0);
        chk("abort_ready", ready1, 1'b1);
        chk("abort_read_data", rdata1, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        run1(1'b1, 1'b0, 32'h100, 32'h0BADC0DE, lat);
        chk("after_abort_latency", lat, 5);
        chk("after_abort_mem_80", mem1[10'h80], 16'hC0DE);
        chk("after_abort_mem_81", mem1[10'h81], 16'h0BAD);

        // Zero wait states, back-to-back held reads of 0x0 then 0x4
        @(posedge clk); #1;
        rd2 = 1'b1; addr2 = 32'h0;
        pat = '0; rda = '0; rdb = '0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            pat[n] = ready2;
            if (n == 3) begin
                rda = rdata2;
                @(posedge clk); #1;
                addr2 = 32'h4;
            end
            if (n == 7) rdb = rdata2;
        end
        @(posedge clk); #1;
        rd2 = 1'b0;
        chk("w0_ready_pattern", pat, 8'b1000_1000);
        chk("w0_read_0", rda, 32'hA001A000);
        chk("w0_read_4", rdb, 32'hA003A002);

        // Single-beat geometry
        wr3 = 1'b1; addr3 = 32'h6; wdata3 = 16'hA5A5; lat = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (ready3) begin lat = n; break; end
        end
        @(posedge clk); #1;
        wr3 = 1'b0;
        chk("one_beat_wr_latency", lat, 3);
        chk("one_beat_mem_3", mem3[3], 16'hA5A5);
        rd3 = 1'b1; lat = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (ready3) begin lat = n; break; end
        end
        chk("one_beat_rd_latency", lat, 3);
        chk("one_beat_rd_word", rdata3, 16'hA5A5);
        @(posedge clk); #1;
        rd3 = 1'b0;

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/sram_burst_controller.md
SRAM_BURST_CONTROLLER -- requirements
Module: sram_burst_controller

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DATA_WIDTH, 32, CPU-side data word width in bits.
  ADDR_WIDTH, 32, CPU-side byte address width.
  SRAM_DATA_WIDTH, 16, SRAM data bus width.
  SRAM_ADDR_WIDTH, 18, SRAM word address width.
  WAIT_CYCLES, 1, extra clk cycles each SRAM beat is held (0..15).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  single clock; all state updates on the rising edge.
  rst  in  1  asynchronous, active-high reset.
  wr_en  in  1  write request, held by the requester until ready.
  rd_en  in  1  read request, held by the requester until ready.
  address  in  ADDR_WIDTH  byte address.
  write_data  in  DATA_WIDTH  write word.
  read_data  out  DATA_WIDTH  assembled read word.
  ready  out  1  low while a request is in flight (pipeline freeze).
  SRAM_DQ  inout  SRAM_DATA_WIDTH  SRAM data bus.
  SRAM_ADDR  out  SRAM_ADDR_WIDTH  SRAM word address.
  SRAM_WE_N  out  1  active-low write enable.
  SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  out  1 each  tied low.

Function
REQ-003 BEATS SHALL equal DATA_WIDTH/SRAM_DATA_WIDTH; elaboration SHALL fail if this is not an integer >= 1.
REQ-004 Word index SHALL be address >> log2(DATA_WIDTH/8); SRAM_ADDR for beat b SHALL be word_index*BEATS + b, truncated to SRAM_ADDR_WIDTH.
REQ-005 Beat 0 SHALL carry the least-significant SRAM_DATA_WIDTH bits of the word.
REQ-006 States SHALL be IDLE, ACCESS, DONE.
REQ-007 IDLE: on wr_en or rd_en, latch address, write_data and op; go to ACCESS with beat=0, wait=0.
REQ-008 wr_en and rd_en both high in IDLE SHALL be treated as a write.
REQ-009 ACCESS: each beat SHALL last WAIT_CYCLES+1 cycles; after the last cycle of beat BEATS-1, go to DONE; otherwise beat advances.
REQ-010 Write beats: SRAM_WE_N low and SRAM_DQ driven with the beat slice for the whole beat.
REQ-011 Read beats: SRAM_WE_N high, SRAM_DQ high-Z; the beat slice SHALL be captured from SRAM_DQ on the last cycle of the beat.
REQ-012 DONE SHALL last one cycle: ready high, read_data valid (reads); next state IDLE regardless of requests.
REQ-013 ready SHALL equal !(wr_en|rd_en) in IDLE, 0 in ACCESS, 1 in DONE.
REQ-014 Latency: request seen in IDLE at cycle 0, ready high at cycle BEATS*(WAIT_CYCLES+1)+1.
REQ-015 Request inputs SHALL be ignored in ACCESS and DONE; latched values are used throughout.
REQ-016 read_data SHALL hold its last value until the next read completes; writes SHALL NOT change it.
REQ-017 SRAM_DQ SHALL be high-Z in IDLE, DONE and read beats.

Reset
REQ-018 On rst: state IDLE, beat=0, wait=0, read_data=0, SRAM_WE_N=1, SRAM_ADDR=0, SRAM_DQ high-Z, ready per REQ-013.
REQ-019 rst asserted during ACCESS SHALL abort the transfer immediately, without completing the current beat.

Structure
REQ-020 State encoding, SRAM width/address constants and tie-off values SHALL live in the shared constants package.
REQ-021 One sub-module sram_beat_counter SHALL hold the beat and wait counters, with a last-cycle-of-beat and last-beat indication.

Verification (DATA_WIDTH 32, SRAM_DATA_WIDTH 16, WAIT_CYCLES 1 unless noted)
REQ-022 Write 0xDEADBEEF to 0x408: SRAM_ADDR 0x204 gets 0xBEEF, then 0x205 gets 0xDEAD; each beat is 2 cycles with SRAM_WE_N low; ready high at cycle 5.
REQ-023 Read back 0x408: read_data=0xDEADBEEF at the DONE cycle; SRAM_DQ not driven by the controller.
REQ-024 wr_en=rd_en=1 at 0x10 with data 0x12345678: a write SRAM_ADDR 0x8=0x5678, 0x9=0x1234; read_data unchanged.
REQ-025 rst pulse at cycle 2 of a write: SRAM_WE_N=1 and SRAM_DQ high-Z at once; state IDLE; next request runs a full transfer.
REQ-026 WAIT_CYCLES=0, back-to-back held reads of 0x0 then 0x4: ready pulses high at cycles 3 and 7.
REQ-027 DATA_WIDTH=SRAM_DATA_WIDTH=16: a single beat; write 0xA5A5 to 0x6 reaches SRAM_ADDR 0x3; ready high at cycle 3.
